// File: rtl/instruction_loader.sv
// Byte-stream to instruction-RAM writer: takes a word count N followed by 2*N
// little-endian bytes and emits one word write per byte pair at stride-4 byte addresses.
module instruction_loader #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int ADDR_STRIDE = 4,
  parameter int MAX_WORDS   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [6:0]            words_written
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    LO,
    HI,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

  state_t     state;
  state_t     state_next;
  logic [6:0] word_cnt;
  logic [7:0] lo_byte;
  logic       accept;
  logic       count_bad;
  logic       last_word;

  assign accept    = in_valid & in_ready;
  assign count_bad = (in_data == 8'd0) || ({1'b0, in_data} > MAX_N);
  // words_written doubles as the word index of the write in progress
  assign last_word = ((words_written + 7'd1) == word_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = COUNT;
      end
      COUNT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = count_bad ? ERR : LO;
      end
      LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = HI;
      end
      HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = WRITE;
      end
      WRITE: begin
        we         = 1'b1;
        busy       = 1'b1;
        state_next = last_word ? DONE : LO;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_next = COUNT;
      end
      default: state_next = IDLE;
    endcase
  end

  // wdata/waddr only change on the edge that enters WRITE, so they hold while we=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt      <= '0;
      lo_byte       <= '0;
      waddr         <= '0;
      wdata         <= '0;
      words_written <= '0;
    end else begin
      if (((state == IDLE) || (state == ERR)) && start) begin
        words_written <= '0;
      end
      if ((state == COUNT) && accept) begin
        word_cnt <= in_data[6:0];
      end
      if ((state == LO) && accept) begin
        lo_byte <= in_data;
      end
      if ((state == HI) && accept) begin
        wdata <= DATA_WIDTH'({in_data, lo_byte});
        waddr <= ADDR_WIDTH'(int'(words_written) * ADDR_STRIDE);
      end
      if (state == WRITE) begin
        words_written <= words_written + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a queue of expected writes built from
// the byte stream is checked against every cycle of the write port.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  words_written;

  instruction_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
    .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  wr_t         exp_q[$];
  wr_t         e_m;
  logic [7:0]  last_a = 8'h00;
  logic [15:0] last_d = 16'h0000;
  int          done_cnt = 0;
  int          exp_done = 0;
  logic [7:0]  stim [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // every cycle: a write must match the next expected word, otherwise the port holds
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (we) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_we: write waddr=%0h wdata=%0h, expected no write", waddr, wdata);
        end else begin
          e_m = exp_q.pop_front();
          chk("we_waddr", 32'(waddr), 32'(e_m.a));
          chk("we_wdata", 32'(wdata), 32'(e_m.d));
          last_a = e_m.a;
          last_d = e_m.d;
        end
      end else begin
        chk("hold_waddr", 32'(waddr), 32'(last_a));
        chk("hold_wdata", 32'(wdata), 32'(last_d));
      end
    end
  end

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_end;
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: busy=%0b after %0d cycles, expected 0", busy, n);
    end
    @(negedge clk);
  endtask

  task automatic do_load(input int n, input bit stall, input string tag);
    bit legal;
    legal = (n >= 1) && (n <= 64);
    if (legal) begin
      for (int i = 0; i < n; i++) exp_q.push_back({8'(i * 4), stim[2*i+1], stim[2*i]});
    end
    pulse_start();
    send(8'(n), stall);
    if (legal) begin
      for (int i = 0; i < 2 * n; i++) send(stim[i], stall);
      exp_done++;
    end
    wait_end();
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_words_written"}, 32'(words_written), legal ? 32'(n) : 32'd0);
    chk({tag, "_error"}, 32'(error), legal ? 32'd0 : 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset;
    #2 rst_n = 1'b0;
    exp_q.delete();
    last_a = 8'h00;
    last_d = 16'h0000;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_words_written", 32'(words_written), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // basic two-word load
    stim[0] = 8'h34; stim[1] = 8'h12; stim[2] = 8'hCD; stim[3] = 8'hAB;
    do_load(2, 1'b0, "t2");
    chk("t2_last_waddr", 32'(waddr), 32'h04);
    chk("t2_last_wdata", 32'(wdata), 32'hABCD);
    chk("t2_words_lit", 32'(words_written), 32'd2);

    // bytes offered while idle are not taken
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // same load with random valid gaps
    do_load(2, 1'b1, "t3");

    // illegal counts, then recovery
    do_load(0, 1'b0, "t4_n00");
    chk("t4_n00_in_ready", 32'(in_ready), 32'd0);
    do_load(65, 1'b0, "t4_n41");
    stim[0] = 8'hEF; stim[1] = 8'hBE;
    do_load(1, 1'b0, "t4_n01");
    chk("t4_wdata_lit", 32'(wdata), 32'hBEEF);
    chk("t4_waddr_lit", 32'(waddr), 32'h00);

    // full 64-word program
    for (int i = 0; i < 128; i++) stim[i] = 8'($urandom);
    do_load(64, 1'b1, "t5");
    chk("t5_last_waddr", 32'(waddr), 32'hFC);
    chk("t5_words_lit", 32'(words_written), 32'd64);

    // start ignored while busy, then reset mid-load
    for (int i = 0; i < 6; i++) stim[i] = 8'(i + 1);
    for (int i = 0; i < 3; i++) exp_q.push_back({8'(i * 4), stim[2*i+1], stim[2*i]});
    pulse_start();
    send(8'd3, 1'b0);
    send(stim[0], 1'b0);
    pulse_start();
    chk("t6_busy_after_start", 32'(busy), 32'd1);
    chk("t6_ready_after_start", 32'(in_ready), 32'd1);
    send(stim[1], 1'b0);
    send(stim[2], 1'b0);
    chk("t6_words_before_rst", 32'(words_written), 32'd1);
    chk("t6_pending_before_rst", 32'(exp_q.size()), 32'd2);
    chk("t6_wdata_word0", 32'(wdata), 32'h0201);
    do_reset();
    repeat (5) @(negedge clk);
    stim[0] = 8'h11; stim[1] = 8'h22;
    do_load(1, 1'b0, "t6_restart");
    chk("t6_restart_waddr", 32'(waddr), 32'h00);
    chk("t6_restart_wdata", 32'(wdata), 32'h2211);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
